motion_seq: RTL

- Consumes the three parameter bytes and the data-count nibble from the UART receive stage.
- Turns them into step/direction pulse trains for a two-axis stepper stage.
- Each command runs as a single trajectory: line, square or diagonal.
- Sits between the UART receiver and the external stepper drivers.

---
 rtl/motion_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/motion_seq.sv
// motion_seq: turns a latched (shape, length, speed) command into
// step/dir pulse trains for a two-axis stepper stage.
//
// Ports:
//   clk, rst        : clock, async active-low reset
//   p1, p2, p3      : shape, length byte, speed byte
//   d_n             : parameter count from the receiver (==4 edge triggers)
//   go, abort       : re-run request, stop request
//   step_x/y, dir_x/y : registered stepper driver outputs
//   seg             : current segment index
//   busy, done, err : status
module motion_seq #(
  parameter int DIV_BASE  = 1843,
  parameter int SPD_MAX   = 20,
  parameter int STEP_UNIT = 16,
  parameter int PULSE_W   = 92,
  parameter int DIR_SETUP = 184
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] p1,
  input  logic [7:0] p2,
  input  logic [7:0] p3,
  input  logic [3:0] d_n,
  input  logic       go,
  input  logic       abort,
  output logic       step_x,
  output logic       dir_x,
  output logic       step_y,
  output logic       dir_y,
  output logic [1:0] seg,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int SW = $clog2(DIR_SETUP + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, RUN, NEXT, DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]    shape;
  logic [7:0]    len;
  logic [6:0]    spd_b;
  logic [7:0]    spd;
  logic [15:0]   total;
  logic [15:0]   sc;
  logic [23:0]   period;
  logic [23:0]   pc;
  logic [SW-1:0] su_cnt;
  logic          d4_q;
  logic          trig;
  logic          bad;
  logic          pc_end;
  logic          sc_end;
  logic          su_end;
  logic          ax_x;
  logic          ax_y;
  logic          halt;

  assign trig   = ((d_n == 4'd4) && !d4_q) || go;
  assign bad    = (shape == 8'd0) || (shape > 8'd4)
               || (len == 8'd0);
  assign pc_end = pc == period - 24'd1;
  assign sc_end = sc == total - 16'd1;
  assign su_end = su_cnt == SW'(DIR_SETUP - 1);
  assign halt   = abort && (state != IDLE);

  // square alternates X/Y by segment parity
  assign ax_x = (shape == 8'd1) || (shape == 8'd4)
             || ((shape == 8'd3) && !seg[0]);
  assign ax_y = (shape == 8'd2) || (shape == 8'd4)
             || ((shape == 8'd3) && seg[0]);

  assign busy = state inside {LOAD, SETUP, RUN, NEXT};
  assign done = state == DONE;

  always_comb begin
    spd = {1'b0, spd_b};
    if (spd < 8'd1)
      spd = 8'd1;
    else if (spd > 8'(SPD_MAX))
      spd = 8'(SPD_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (trig) state_n = LOAD;
      LOAD:    state_n = bad ? IDLE : SETUP;
      SETUP:   if (su_end) state_n = RUN;
      RUN:     if (pc_end && sc_end) state_n = NEXT;
      NEXT:    state_n = ((shape == 8'd3) && (seg != 2'd3))
                         ? SETUP : DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (halt)
      state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d4_q   <= 1'b0;
      shape  <= '0;
      len    <= '0;
      spd_b  <= '0;
      total  <= '0;
      period <= '0;
      pc     <= '0;
      sc     <= '0;
      su_cnt <= '0;
      seg    <= '0;
      step_x <= 1'b0;
      step_y <= 1'b0;
      dir_x  <= 1'b0;
      dir_y  <= 1'b0;
      err    <= 1'b0;
    end else begin
      d4_q   <= d_n == 4'd4;
      step_x <= 1'b0;
      step_y <= 1'b0;
      if (!halt) begin
        case (state)
          IDLE: if (trig) begin
            shape <= p1;
            len   <= p2;
            spd_b <= p3[7:1];
            err   <= 1'b0;
          end
          LOAD: begin
            if (bad) begin
              err <= 1'b1;
            end else begin
              total  <= 16'(len) * 16'(STEP_UNIT);
              period <= 24'(DIV_BASE)
                      * (24'(SPD_MAX + 1) - 24'(spd));
              seg    <= 2'd0;
              su_cnt <= '0;
            end
          end
          SETUP: begin
            su_cnt <= su_cnt + SW'(1);
            pc     <= '0;
            sc     <= '0;
            if (shape == 8'd3) begin
              case (seg)
                2'd0:    dir_x <= 1'b1;
                2'd1:    dir_y <= 1'b1;
                2'd2:    dir_x <= 1'b0;
                default: dir_y <= 1'b0;
              endcase
            end else begin
              if (shape != 8'd2) dir_x <= 1'b1;
              if (shape != 8'd1) dir_y <= 1'b1;
            end
          end
          RUN: begin
            step_x <= ax_x && (pc < 24'(PULSE_W));
            step_y <= ax_y && (pc < 24'(PULSE_W));
            if (pc_end) begin
              pc <= '0;
              sc <= sc + 16'd1;
            end else begin
              pc <= pc + 24'd1;
            end
          end
          NEXT: begin
            if ((shape == 8'd3) && (seg != 2'd3)) begin
              seg    <= seg + 2'd1;
              su_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
